// File: rtl/filter_mode_ctrl.sv
// Sequenced filter-mode controller: debounced NEXT/PREV keys and an optional frame timer step a
// pending mode, which becomes the active mode (and the oSW filter-select word) only on a VSYNC fall.
module filter_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int AUTO_FRAMES     = 120,
    parameter int DB_W            = 19,
    parameter int FR_W            = 8
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iKEY_NEXT,
    input  logic       iKEY_PREV,
    input  logic       iVS,
    input  logic       iAUTO,
    output logic [9:0] oSW,
    output logic [2:0] oMODE,
    output logic       oPENDING,
    output logic       oCHANGED
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(AUTO_FRAMES - 1);

    // Index 0 = NEXT key, index 1 = PREV key.
    logic [1:0]      key_raw;
    logic [1:0]      key_s1_q, key_s2_q;
    logic [1:0]      db_q, db_d;
    logic [1:0]      press_q, press_d;
    logic [1:0]      arm_q, arm_d;
    logic [1:0]      flush_q;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];

    logic            vs_s1_q, vs_s2_q, vs_s3_q, vs_edge_q;

    logic [2:0]      pend_q, pend_d;
    logic [2:0]      active_q, active_d;
    logic [FR_W-1:0] fr_q, fr_d;
    logic [9:0]      sw_q, sw_d;
    logic            pending_q, pending_d;
    logic            changed_q, changed_d;
    logic [2:0]      pend_inc, pend_dec;

    assign key_raw = {iKEY_PREV, iKEY_NEXT};

    // The counter measures how long the synced level has disagreed with the debounced state.
    // A key is armed only once it has been seen released after reset, so a key held through
    // reset cannot produce a press when reset lifts.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_d[k]    = db_q[k];
            cnt_d[k]   = cnt_q[k];
            press_d[k] = 1'b0;
            arm_d[k]   = arm_q[k];
            if (key_s2_q[k] == db_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == DB_LAST) begin
                db_d[k]    = key_s2_q[k];
                cnt_d[k]   = '0;
                press_d[k] = arm_q[k] & ~key_s2_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
            if (flush_q[1] && db_q[k] && key_s2_q[k]) begin
                arm_d[k] = 1'b1;
            end
        end
    end

    assign pend_inc = (pend_q == 3'd6) ? 3'd0 : pend_q + 3'd1;
    assign pend_dec = (pend_q == 3'd0) ? 3'd6 : pend_q - 3'd1;

    always_comb begin
        pend_d = pend_q;
        fr_d   = fr_q;
        if (|press_q) begin
            fr_d = '0;
            if (press_q == 2'b01) begin
                pend_d = pend_inc;
            end else if (press_q == 2'b10) begin
                pend_d = pend_dec;
            end
        end else if (vs_edge_q && iAUTO) begin
            if (fr_q == FR_LAST) begin
                fr_d   = '0;
                pend_d = pend_inc;
            end else begin
                fr_d = fr_q + 1'b1;
            end
        end
        if (!iAUTO) begin
            fr_d = '0;
        end
    end

    // Commit takes pend as it stood before this cycle's update.
    always_comb begin
        active_d  = vs_edge_q ? pend_q : active_q;
        changed_d = vs_edge_q && (pend_q != active_q);
        pending_d = (pend_d != active_d);
        sw_d      = (active_d == 3'd0) ? 10'h000 : {2'b01, 5'b00000, active_d - 3'd1};
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            key_s1_q  <= 2'b11;
            key_s2_q  <= 2'b11;
            db_q      <= 2'b11;
            press_q   <= 2'b00;
            arm_q     <= 2'b00;
            flush_q   <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_s3_q   <= 1'b1;
            vs_edge_q <= 1'b0;
            pend_q    <= 3'd0;
            active_q  <= 3'd0;
            fr_q      <= '0;
            sw_q      <= 10'h000;
            pending_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            key_s1_q  <= key_raw;
            key_s2_q  <= key_s1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            arm_q     <= arm_d;
            flush_q   <= {flush_q[0], 1'b1};
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            vs_s1_q   <= iVS;
            vs_s2_q   <= vs_s1_q;
            vs_s3_q   <= vs_s2_q;
            vs_edge_q <= vs_s3_q & ~vs_s2_q;
            pend_q    <= pend_d;
            active_q  <= active_d;
            fr_q      <= fr_d;
            sw_q      <= sw_d;
            pending_q <= pending_d;
            changed_q <= changed_d;
        end
    end

    assign oSW      = sw_q;
    assign oMODE    = active_q;
    assign oPENDING = pending_q;
    assign oCHANGED = changed_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Directed bench for filter_mode_ctrl with a small mode model; each VS pulse pushes the expected
// committed state to a queue that is popped once the DUT output has settled.
module tb_filter_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_next = 1'b1;
    logic       key_prev = 1'b1;
    logic       vs = 1'b1;
    logic       auto_en = 1'b0;
    logic [9:0] sw;
    logic [2:0] mode;
    logic       pending;
    logic       changed;

    int n_checks = 0;
    int n_err    = 0;
    int chg_cnt  = 0;

    logic [2:0] m_pend, m_active;
    int         m_fr;
    bit         m_auto;
    logic [14:0] exp_q[$];

    filter_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_FRAMES    (3),
        .DB_W           (3),
        .FR_W           (2)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iKEY_NEXT (key_next),
        .iKEY_PREV (key_prev),
        .iVS       (vs),
        .iAUTO     (auto_en),
        .oSW       (sw),
        .oMODE     (mode),
        .oPENDING  (pending),
        .oCHANGED  (changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (changed === 1'b1) chg_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] m_inc(input logic [2:0] m);
        return (m == 3'd6) ? 3'd0 : m + 3'd1;
    endfunction

    function automatic logic [2:0] m_dec(input logic [2:0] m);
        return (m == 3'd0) ? 3'd6 : m - 3'd1;
    endfunction

    function automatic logic [9:0] sw_of(input logic [2:0] m);
        logic [9:0] r;
        r = 10'h000;
        if (m != 3'd0) r = 10'h100 | {7'd0, m - 3'd1};
        return r;
    endfunction

    task automatic model_reset();
        m_pend = 3'd0; m_active = 3'd0; m_fr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(5);
    endtask

    task automatic set_auto(input bit v);
        auto_en = v;
        m_auto  = v;
        if (!v) m_fr = 0;
    endtask

    task automatic press(input bit nxt, input bit prv);
        if (nxt) key_next = 1'b0;
        if (prv) key_prev = 1'b0;
        tick(10);
        key_next = 1'b1;
        key_prev = 1'b1;
        tick(10);
        if (nxt && !prv) m_pend = m_inc(m_pend);
        if (prv && !nxt) m_pend = m_dec(m_pend);
        if (nxt || prv) m_fr = 0;
    endtask

    task automatic vs_pulse(input string tag);
        logic        chg;
        logic [14:0] e;
        int          c0;
        chg      = (m_pend != m_active);
        m_active = m_pend;
        if (m_auto) begin
            if (m_fr == 2) begin
                m_pend = m_inc(m_pend);
                m_fr   = 0;
            end else begin
                m_fr++;
            end
        end
        exp_q.push_back({m_pend != m_active, chg, m_active, sw_of(m_active)});
        c0 = chg_cnt;
        vs = 1'b0;
        tick(3);
        vs = 1'b1;
        tick(5);
        e = exp_q.pop_front();
        check({tag, ".mode"}, 32'(mode), 32'(e[12:10]));
        check({tag, ".sw"}, 32'(sw), 32'(e[9:0]));
        check({tag, ".changed"}, 32'(chg_cnt - c0), 32'(e[13]));
        check({tag, ".pending"}, 32'(pending), 32'(e[14]));
    endtask

    initial begin
        int c0;
        model_reset();
        m_auto = 1'b0;

        // Reset state, then idle VS pulses.
        tick(3);
        check("rst.sw", 32'(sw), 32'h0);
        check("rst.mode", 32'(mode), 32'h0);
        check("rst.pending", 32'(pending), 32'h0);
        check("rst.changed", 32'(changed), 32'h0);
        rst = 1'b0;
        tick(5);
        c0 = chg_cnt;
        for (int i = 0; i < 20; i++) vs_pulse("idle");
        check("idle.no_changed", 32'(chg_cnt - c0), 32'h0);

        // Bounce rejected, then a real press.
        key_next = 1'b0;
        tick(2);
        key_next = 1'b1;
        tick(10);
        check("bounce.pending", 32'(pending), 32'h0);
        press(1'b1, 1'b0);
        check("press.pending", 32'(pending), 32'h1);
        check("press.mode_held", 32'(mode), 32'h0);
        vs_pulse("first");

        // Full forward wrap then PREV from 0.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            press(1'b1, 1'b0);
            vs_pulse($sformatf("wrap%0d", i));
        end
        check("wrap.end_mode", 32'(mode), 32'h0);
        press(1'b0, 1'b1);
        vs_pulse("prev_from0");
        check("prev.mode6", 32'(mode), 32'h6);
        check("prev.sw", 32'(sw), 32'h105);

        // Simultaneous NEXT and PREV.
        do_reset();
        press(1'b1, 1'b0);
        vs_pulse("sim_setup");
        press(1'b1, 1'b1);
        check("sim.pending", 32'(pending), 32'h0);
        vs_pulse("sim_after");

        // Key event coincident with a VS edge commits one VS edge later.
        c0 = chg_cnt;
        key_next = 1'b0;
        tick(3);
        vs = 1'b0;
        tick(2);
        vs = 1'b1;
        tick(5);
        key_next = 1'b1;
        tick(10);
        m_pend = m_inc(m_pend);
        check("coinc.mode_held", 32'(mode), 32'h1);
        check("coinc.pending", 32'(pending), 32'h1);
        check("coinc.no_changed", 32'(chg_cnt - c0), 32'h0);
        vs_pulse("coinc_commit");
        check("coinc.mode2", 32'(mode), 32'h2);

        // Auto-cycle over ten frames.
        do_reset();
        set_auto(1'b1);
        for (int i = 0; i < 10; i++) vs_pulse($sformatf("auto%0d", i));
        check("auto.mode3", 32'(mode), 32'h3);

        // A key press clears the frame counter mid-count.
        do_reset();
        vs_pulse("fr0");
        vs_pulse("fr1");
        press(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) vs_pulse($sformatf("frclr%0d", i));
        check("frclr.mode2", 32'(mode), 32'h2);
        set_auto(1'b0);

        // Reset mid-debounce with pend=4, active=2.
        do_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        vs_pulse("mid_setup");
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("mid.mode2", 32'(mode), 32'h2);
        check("mid.pending", 32'(pending), 32'h1);
        key_next = 1'b0;
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("async.sw", 32'(sw), 32'h0);
        check("async.mode", 32'(mode), 32'h0);
        check("async.pending", 32'(pending), 32'h0);
        check("async.changed", 32'(changed), 32'h0);
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(20);
        check("held.no_event", 32'(pending), 32'h0);
        key_next = 1'b1;
        tick(15);
        press(1'b1, 1'b0);
        check("held.new_press", 32'(pending), 32'h1);
        vs_pulse("held_commit");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
